// File: rtl/movegen_pkg.sv
// Shared definitions for the move-generation sequencer and its shadow board.
package movegen_pkg;

    // Piece codes: bit 3 is the colour, bits [2:0] the piece kind.
    localparam logic [3:0] PC_EMPTY  = 4'd0;
    localparam logic [3:0] PC_KING   = 4'd1;
    localparam logic [3:0] PC_QUEEN  = 4'd2;
    localparam logic [3:0] PC_ROOK   = 4'd3;
    localparam logic [3:0] PC_BISHOP = 4'd4;
    localparam logic [3:0] PC_KNIGHT = 4'd5;
    localparam logic [3:0] PC_PAWN   = 4'd6;
    localparam int         WHITE_BIT = 3;

    // Square index, 0 = a1 .. 63 = h8.
    typedef logic [5:0] sq_t;
    localparam sq_t SQ_LAST = 6'd63;

    // Castle-right bit positions.
    localparam int CR_BQ = 0;
    localparam int CR_BK = 1;
    localparam int CR_WQ = 2;
    localparam int CR_WK = 3;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        ATTACK = 3'd2,
        SCAN   = 3'd3,
        EMIT   = 3'd4,
        OUT    = 3'd5,
        FIN    = 3'd6
    } movegen_seq_state_t;

    // True when the code holds a piece belonging to the side to move.
    function automatic logic is_own_piece(input logic [3:0] code, input logic wtp);
        return (code[2:0] != 3'd0) && (code[WHITE_BIT] == wtp);
    endfunction

endpackage

// File: rtl/movegen_shadow_board.sv
// 64x4 shadow copy of the position with a registered own-piece lookup.
module movegen_shadow_board
    import movegen_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       shift_en,
    input  logic [3:0] shift_data,
    input  sq_t        lookup_idx,
    input  logic       wtp,
    output logic       own_at_idx
);

    logic [255:0] cells_r;

    // Shift chain: a new word enters at square 0 and older words move toward square 63.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cells_r <= '0;
        end else if (shift_en) begin
            cells_r <= {cells_r[251:0], shift_data};
        end else begin
            cells_r <= cells_r;
        end
    end

    // Registered lookup: answers for the index presented in the previous cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            own_at_idx <= 1'b0;
        end else begin
            own_at_idx <= is_own_piece(cells_r[{lookup_idx, 2'b00} +: 4], wtp);
        end
    end

endmodule

// File: rtl/movegen_sequencer.sv
// Sequences the 64-square move-generation array through one generation pass
// and streams one (from, targets) record per productive own piece.
module movegen_sequencer
    import movegen_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1,
    parameter bit EMIT_EMPTY    = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        wtp_in,
    input  logic [3:0]  castle_rights_in,
    input  logic [7:0]  ep_file_in,
    input  logic        s_pos_valid,
    input  logic [3:0]  s_pos_data,
    output logic        s_pos_ready,
    output logic        board_pos_valid,
    output logic [3:0]  board_pos_data,
    output logic        board_wtp,
    output logic [3:0]  board_castle_rights,
    output logic [7:0]  board_ep_file,
    output logic        board_load_attackers,
    output logic [63:0] board_emit_move,
    input  logic [63:0] board_target,
    output logic        m_valid,
    output logic [5:0]  m_from,
    output logic [63:0] m_targets,
    input  logic        m_ready,
    output logic        busy,
    output logic        done,
    output logic [6:0]  src_count
);

    localparam int SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);

    movegen_seq_state_t  state_r;
    logic [6:0]          load_cnt_r;
    sq_t                 scan_idx_r;
    logic [SETTLE_W-1:0] settle_cnt_r;

    logic pos_accept_s;
    logic own_s;
    logic settle_last_s;
    logic emit_hit_s;
    logic advance_s;
    sq_t  lookup_idx_s;

    assign pos_accept_s    = s_pos_valid & s_pos_ready;
    assign board_pos_valid = pos_accept_s;
    assign board_pos_data  = pos_accept_s ? s_pos_data : 4'd0;
    assign settle_last_s   = (settle_cnt_r == SETTLE_LAST);
    assign emit_hit_s      = (board_target != 64'd0) || EMIT_EMPTY;

    // Decide whether the scan index moves on this cycle.
    always_comb begin
        advance_s = 1'b0;
        case (state_r)
            SCAN:    advance_s = !own_s;
            EMIT:    advance_s = settle_last_s && !emit_hit_s;
            OUT:     advance_s = m_ready;
            default: advance_s = 1'b0;
        endcase
    end

    // Present next cycle's scan index so the registered lookup lines up with SCAN.
    always_comb begin
        lookup_idx_s = scan_idx_r;
        if (state_r == ATTACK) begin
            lookup_idx_s = 6'd0;
        end else if (advance_s) begin
            lookup_idx_s = scan_idx_r + 6'd1;
        end else begin
            lookup_idx_s = scan_idx_r;
        end
    end

    movegen_shadow_board u_shadow (
        .clk        (clk),
        .rst_n      (rst_n),
        .shift_en   (pos_accept_s),
        .shift_data (s_pos_data),
        .lookup_idx (lookup_idx_s),
        .wtp        (board_wtp),
        .own_at_idx (own_s)
    );

    // Pass controller with all control and stream outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r              <= IDLE;
            load_cnt_r           <= 7'd0;
            scan_idx_r           <= 6'd0;
            settle_cnt_r         <= '0;
            s_pos_ready          <= 1'b0;
            board_wtp            <= 1'b0;
            board_castle_rights  <= 4'd0;
            board_ep_file        <= 8'd0;
            board_load_attackers <= 1'b0;
            board_emit_move      <= 64'd0;
            m_valid              <= 1'b0;
            m_from               <= 6'd0;
            m_targets            <= 64'd0;
            busy                 <= 1'b0;
            done                 <= 1'b0;
            src_count            <= 7'd0;
        end else begin
            done                 <= 1'b0;
            board_load_attackers <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        board_wtp           <= wtp_in;
                        board_castle_rights <= castle_rights_in;
                        board_ep_file       <= ep_file_in;
                        src_count           <= 7'd0;
                        load_cnt_r          <= 7'd0;
                        busy                <= 1'b1;
                        s_pos_ready         <= 1'b1;
                        state_r             <= LOAD;
                    end
                end
                LOAD: begin
                    if (pos_accept_s) begin
                        if (load_cnt_r == 7'd63) begin
                            load_cnt_r           <= 7'd0;
                            s_pos_ready          <= 1'b0;
                            board_load_attackers <= 1'b1;
                            state_r              <= ATTACK;
                        end else begin
                            load_cnt_r <= load_cnt_r + 7'd1;
                        end
                    end
                end
                ATTACK: begin
                    scan_idx_r <= 6'd0;
                    state_r    <= SCAN;
                end
                SCAN: begin
                    if (own_s) begin
                        board_emit_move <= 64'd1 << scan_idx_r;
                        settle_cnt_r    <= '0;
                        state_r         <= EMIT;
                    end else if (scan_idx_r == SQ_LAST) begin
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state_r <= FIN;
                    end else begin
                        scan_idx_r <= scan_idx_r + 6'd1;
                    end
                end
                EMIT: begin
                    if (settle_last_s) begin
                        m_targets       <= board_target;
                        m_from          <= scan_idx_r;
                        board_emit_move <= 64'd0;
                        if (emit_hit_s) begin
                            m_valid <= 1'b1;
                            state_r <= OUT;
                        end else if (scan_idx_r == SQ_LAST) begin
                            done    <= 1'b1;
                            busy    <= 1'b0;
                            state_r <= FIN;
                        end else begin
                            scan_idx_r <= scan_idx_r + 6'd1;
                            state_r    <= SCAN;
                        end
                    end else begin
                        settle_cnt_r <= settle_cnt_r + 1'b1;
                    end
                end
                OUT: begin
                    if (m_ready) begin
                        m_valid <= 1'b0;
                        if (src_count != 7'd64) begin
                            src_count <= src_count + 7'd1;
                        end
                        if (scan_idx_r == SQ_LAST) begin
                            done    <= 1'b1;
                            busy    <= 1'b0;
                            state_r <= FIN;
                        end else begin
                            scan_idx_r <= scan_idx_r + 6'd1;
                            state_r    <= SCAN;
                        end
                    end
                end
                FIN: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_movegen_sequencer.sv
// Directed bench for movegen_sequencer with a table-driven model of the square array.
module tb_movegen_sequencer;
    import movegen_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        wtp_in = 1'b0;
    logic [3:0]  castle_rights_in = 4'd0;
    logic [7:0]  ep_file_in = 8'd0;
    logic        s_pos_valid = 1'b0;
    logic [3:0]  s_pos_data = 4'd0;
    logic        s_pos_ready;
    logic        board_pos_valid;
    logic [3:0]  board_pos_data;
    logic        board_wtp;
    logic [3:0]  board_castle_rights;
    logic [7:0]  board_ep_file;
    logic        board_load_attackers;
    logic [63:0] board_emit_move;
    logic [63:0] board_target;
    logic        m_valid;
    logic [5:0]  m_from;
    logic [63:0] m_targets;
    logic        m_ready = 1'b0;
    logic        busy;
    logic        done;
    logic [6:0]  src_count;

    int n_tests = 0;
    int n_fail  = 0;

    logic [3:0]  pos     [64];
    logic [63:0] tgt_tab [64];
    int          exp_from [$];
    logic [63:0] exp_tgt  [$];
    logic        cur_wtp;
    logic [3:0]  cur_cr;
    logic [7:0]  cur_ep;

    always #5 clk = ~clk;

    movegen_sequencer #(.SETTLE_CYCLES(2), .EMIT_EMPTY(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .wtp_in(wtp_in),
        .castle_rights_in(castle_rights_in), .ep_file_in(ep_file_in),
        .s_pos_valid(s_pos_valid), .s_pos_data(s_pos_data), .s_pos_ready(s_pos_ready),
        .board_pos_valid(board_pos_valid), .board_pos_data(board_pos_data),
        .board_wtp(board_wtp), .board_castle_rights(board_castle_rights),
        .board_ep_file(board_ep_file), .board_load_attackers(board_load_attackers),
        .board_emit_move(board_emit_move), .board_target(board_target),
        .m_valid(m_valid), .m_from(m_from), .m_targets(m_targets), .m_ready(m_ready),
        .busy(busy), .done(done), .src_count(src_count)
    );

    // Square-array stand-in: targets of whichever square is strobed.
    always_comb begin
        board_target = 64'd0;
        for (int i = 0; i < 64; i++) begin
            if (board_emit_move[i]) board_target = board_target | tgt_tab[i];
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Strobe sanity whenever a source square is being driven.
    always @(negedge clk) begin
        if (rst_n && board_emit_move != 64'd0) begin
            chk("emit_onehot", 64'($countones(board_emit_move)), 64'd1);
            chk("emit_vs_attack", 64'(board_load_attackers), 64'd0);
        end
    end

    task automatic clear_board();
        for (int i = 0; i < 64; i++) begin
            pos[i] = 4'd0;
            tgt_tab[i] = 64'd0;
        end
    endtask

    task automatic setup_start();
        logic [3:0] back [8];
        back = '{4'h3, 4'h5, 4'h4, 4'h2, 4'h1, 4'h4, 4'h5, 4'h3};
        clear_board();
        for (int f = 0; f < 8; f++) begin
            pos[f]      = back[f] | 4'h8;
            pos[8 + f]  = 4'hE;
            pos[48 + f] = 4'h6;
            pos[56 + f] = back[f];
            tgt_tab[8 + f] = (64'd1 << (16 + f)) | (64'd1 << (24 + f));
        end
        tgt_tab[1] = (64'd1 << 16) | (64'd1 << 18);
        tgt_tab[6] = (64'd1 << 21) | (64'd1 << 23);
    endtask

    task automatic build_exp(input logic w);
        exp_from.delete();
        exp_tgt.delete();
        for (int i = 0; i < 64; i++) begin
            if (pos[i][2:0] != 3'd0 && pos[i][3] == w && tgt_tab[i] != 64'd0) begin
                exp_from.push_back(i);
                exp_tgt.push_back(tgt_tab[i]);
            end
        end
    endtask

    task automatic start_pass(input logic w, input logic [3:0] cr, input logic [7:0] ep);
        cur_wtp = w; cur_cr = cr; cur_ep = ep;
        @(negedge clk);
        start = 1'b1; wtp_in = w; castle_rights_in = cr; ep_file_in = ep;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", 64'(busy), 64'd1);
        chk("latched_wtp", 64'(board_wtp), 64'(w));
        chk("latched_rights", 64'(board_castle_rights), 64'(cr));
        chk("latched_ep", 64'(board_ep_file), 64'(ep));
        chk("src_count_cleared", 64'(src_count), 64'd0);
    endtask

    task automatic load_board(input bit stall, input bit glitch);
        int sent = 0;
        int cyc = 0;
        while (sent < 64 && cyc < 400) begin
            @(negedge clk);
            s_pos_valid = stall ? (cyc % 2 == 0) : 1'b1;
            s_pos_data  = pos[63 - sent];
            if (glitch && cyc == 10) begin
                start = 1'b1; wtp_in = ~cur_wtp; castle_rights_in = ~cur_cr; ep_file_in = 8'h10;
            end else begin
                start = 1'b0;
            end
            #1;
            chk("load_ready", 64'(s_pos_ready), 64'd1);
            chk("pos_pass_valid", 64'(board_pos_valid), 64'(s_pos_valid));
            if (s_pos_valid) chk("pos_pass_data", 64'(board_pos_data), 64'(s_pos_data));
            if (s_pos_valid && s_pos_ready) sent++;
            cyc++;
        end
        chk("load_complete", 64'(sent), 64'd64);
        @(negedge clk);
        start = 1'b0; s_pos_valid = 1'b1;
        chk("attack_strobe", 64'(board_load_attackers), 64'd1);
        chk("ready_after_64", 64'(s_pos_ready), 64'd0);
        #1 chk("no_65th_word", 64'(board_pos_valid), 64'd0);
        @(negedge clk);
        chk("attack_one_cycle", 64'(board_load_attackers), 64'd0);
        s_pos_valid = 1'b0;
    endtask

    task automatic run_pass(input int n_exp, input int hold);
        int got = 0;
        int dones = 0;
        int hold_left = hold;
        bit seen = 1'b0;
        bit fin = 1'b0;
        logic [5:0]  snap_from;
        logic [63:0] snap_tgt;
        m_ready = (hold == 0);
        for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
            @(negedge clk);
            if (m_valid) begin
                if (!seen) begin
                    if (got < exp_from.size()) begin
                        chk("rec_from", 64'(m_from), 64'(exp_from[got]));
                        chk("rec_targets", m_targets, exp_tgt[got]);
                    end else begin
                        chk("extra_record", 64'd1, 64'd0);
                    end
                    got++;
                    seen = 1'b1;
                    snap_from = m_from;
                    snap_tgt = m_targets;
                end else begin
                    chk("hold_from", 64'(m_from), 64'(snap_from));
                    chk("hold_targets", m_targets, snap_tgt);
                    chk("hold_no_emit", board_emit_move, 64'd0);
                end
                if (!m_ready) begin
                    if (hold_left <= 1) m_ready = 1'b1;
                    else hold_left--;
                end
            end else begin
                seen = 1'b0;
            end
            if (done) begin
                dones++;
                fin = 1'b1;
                chk("done_not_busy", 64'(busy), 64'd0);
            end
        end
        chk("pass_finished", 64'(fin), 64'd1);
        chk("record_count", 64'(got), 64'(n_exp));
        chk("src_count", 64'(src_count), 64'(n_exp));
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (done) dones++;
        end
        chk("done_pulses", 64'(dones), 64'd1);
        chk("idle_not_busy", 64'(busy), 64'd0);
        chk("kept_wtp", 64'(board_wtp), 64'(cur_wtp));
        chk("kept_rights", 64'(board_castle_rights), 64'(cur_cr));
        chk("kept_ep", 64'(board_ep_file), 64'(cur_ep));
        m_ready = 1'b0;
    endtask

    initial begin
        bit found;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_ready", 64'(s_pos_ready), 64'd0);
        chk("rst_valid", 64'(m_valid), 64'd0);
        chk("rst_emit", board_emit_move, 64'd0);
        chk("rst_src_count", 64'(src_count), 64'd0);
        rst_n = 1'b1;

        // Start position, white to move; start glitch during load; ready held 20 cycles
        setup_start();
        build_exp(1'b1);
        chk("start_exp_count", 64'(exp_from.size()), 64'd10);
        start_pass(1'b1, 4'hF, 8'h00);
        load_board(1'b0, 1'b1);
        run_pass(10, 20);

        // Lone king on e1 with rook h1, e-file attacked by black rook on e8
        clear_board();
        pos[4] = 4'h9; pos[7] = 4'hB; pos[60] = 4'h3; pos[56] = 4'h1;
        tgt_tab[4] = (64'd1 << 3) | (64'd1 << 5) | (64'd1 << 11) | (64'd1 << 13);
        tgt_tab[7] = (64'd1 << 5) | (64'd1 << 6) | (64'd1 << 15) | (64'd1 << 23) |
                     (64'd1 << 31) | (64'd1 << 39) | (64'd1 << 47) | (64'd1 << 55) | (64'd1 << 63);
        build_exp(1'b1);
        start_pass(1'b1, 4'b1000, 8'h00);
        load_board(1'b0, 1'b0);
        run_pass(2, 0);

        // Same without the black rook: castling target g1 appears, stalled load
        pos[60] = 4'h0;
        tgt_tab[4] = tgt_tab[4] | (64'd1 << 6) | (64'd1 << 12);
        build_exp(1'b1);
        start_pass(1'b1, 4'b1000, 8'h00);
        load_board(1'b1, 1'b0);
        run_pass(2, 0);

        // Black to move: first word lands on h8; empty-target king is skipped
        clear_board();
        pos[63] = 4'h3; pos[60] = 4'h1; pos[4] = 4'h9;
        tgt_tab[63] = (64'd1 << 62) | (64'd1 << 61) | (64'd1 << 55) | (64'd1 << 47);
        tgt_tab[4]  = (64'd1 << 12);
        build_exp(1'b0);
        start_pass(1'b0, 4'b0011, 8'h08);
        load_board(1'b1, 1'b0);
        run_pass(1, 0);

        // Reset in the middle of EMIT, then a full pass
        setup_start();
        build_exp(1'b1);
        start_pass(1'b1, 4'hF, 8'h00);
        load_board(1'b0, 1'b0);
        m_ready = 1'b1;
        found = 1'b0;
        for (int cyc = 0; cyc < 300 && !found; cyc++) begin
            @(negedge clk);
            if (board_emit_move != 64'd0) found = 1'b1;
        end
        chk("emit_reached", 64'(found), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_emit", board_emit_move, 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_valid", 64'(m_valid), 64'd0);
        chk("mid_rst_wtp", 64'(board_wtp), 64'd0);
        chk("mid_rst_rights", 64'(board_castle_rights), 64'd0);
        chk("mid_rst_targets", m_targets, 64'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("mid_rst_no_done", 64'(done), 64'd0);
        end
        rst_n = 1'b1;
        start_pass(1'b1, 4'hF, 8'h00);
        load_board(1'b0, 1'b0);
        run_pass(10, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
